// File: rtl/mclk_pause_ctrl.sv
// Pause controller for the mclk clock gate: drains the mclk domain, holds mclk stopped,
// supports single-cycle stepping while paused and guards the restart. Runs on sclk.
module mclk_pause_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int RESUME_CYCLES = 2,
    parameter int DRAIN_MAX     = 255,
    parameter int CNT_W         = 16
) (
    input  logic             i_sclk,
    input  logic             i_rst_n,
    input  logic             i_pause_req,
    input  logic             i_mclk_idle,
    input  logic             i_step_req,
    input  logic             i_timeout_clr,
    output logic             o_mclk_pause,
    output logic             o_pause_ack,
    output logic [CNT_W-1:0] o_paused_cycles,
    output logic             o_drain_timeout
);

    localparam int MAX_A = (DRAIN_MAX > SETTLE_CYCLES) ? DRAIN_MAX : SETTLE_CYCLES;
    localparam int MAX_C = (MAX_A > RESUME_CYCLES) ? MAX_A : RESUME_CYCLES;
    localparam int CW    = (MAX_C < 2) ? 1 : $clog2(MAX_C);

    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_MAX - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] RESUME_LAST = CW'(RESUME_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SETTLE,
        ST_PAUSED,
        ST_STEP,
        ST_RESUME
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_forced;
    logic            w_clr_paused;
    logic            w_mclk_pause_nxt;
    logic            w_pause_ack_nxt;
    logic [CNT_W-1:0] r_paused_cycles;
    logic            r_mclk_pause;
    logic            r_pause_ack;
    logic            r_drain_timeout;

    // One shared counter times DRAIN, SETTLE and RESUME; it is reloaded on every entry.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_forced     = 1'b0;
        w_clr_paused = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_pause_req) begin
                    w_state_nxt  = ST_DRAIN;
                    w_cnt_nxt    = '0;
                    w_clr_paused = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!i_pause_req) begin
                    w_state_nxt = ST_RUN;
                end else if (i_mclk_idle) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DRAIN_LAST) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                    w_forced    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (!i_pause_req) begin
                    w_state_nxt = ST_RESUME;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_PAUSED;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_PAUSED: begin
                if (!i_pause_req) begin
                    w_state_nxt = ST_RESUME;
                    w_cnt_nxt   = '0;
                end else if (i_step_req) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                if (!i_pause_req) begin
                    w_state_nxt = ST_RESUME;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            ST_RESUME: begin
                if (r_cnt == RESUME_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    assign w_mclk_pause_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_PAUSED);
    assign w_pause_ack_nxt  = (w_state_nxt == ST_PAUSED);

    always_ff @(posedge i_sclk) begin
        if (!i_rst_n) begin
            r_state         <= ST_RUN;
            r_cnt           <= '0;
            r_mclk_pause    <= 1'b0;
            r_pause_ack     <= 1'b0;
            r_paused_cycles <= '0;
            r_drain_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mclk_pause <= w_mclk_pause_nxt;
            r_pause_ack  <= w_pause_ack_nxt;

            if (w_clr_paused) begin
                r_paused_cycles <= '0;
            end else if ((r_state == ST_PAUSED) && (r_paused_cycles != '1)) begin
                r_paused_cycles <= r_paused_cycles + CNT_W'(1);
            end

            // A forced pause on the same cycle as a clear must stay visible.
            if (w_forced) begin
                r_drain_timeout <= 1'b1;
            end else if (i_timeout_clr) begin
                r_drain_timeout <= 1'b0;
            end
        end
    end

    assign o_mclk_pause    = r_mclk_pause;
    assign o_pause_ack     = r_pause_ack;
    assign o_paused_cycles = r_paused_cycles;
    assign o_drain_timeout = r_drain_timeout;

endmodule
